fixed_to_float: RTL and testbench
=================================

// Module: fixed_to_float
// PURPOSE
//  Converts signed two's-complement fixed-point values to IEEE-754 binary64 (double).
//  Synthesizable 4-stage AXI-Stream pipeline with round-to-nearest-even.
//  Inverse direction of the float-to-fixed converter; feeds fixed results back into the double FP datapath.
// PARAMETERS
//  SIZE       64  input fixed-point width, 2..64; output is always 64-bit double
//  FRAC_BITS  0   input fraction bits (value = s_axis_a_tdata * 2^-FRAC_BITS), 0..SIZE-1
// PORTS
//  aclk                  in   1     clock, all logic on rising edge
//  aresetn               in   1     asynchronous, active-high reset (asserted = 1)
//  s_axis_a_tdata        in   SIZE  signed fixed-point operand
//  s_axis_a_tvalid       in   1     operand valid
//  s_axis_a_tready       out  1     operand accepted when tvalid && tready
//  m_axis_result_tdata   out  64    double result {sign, exp[10:0], mant[51:0]}
//  m_axis_result_tvalid  out  1     result valid
//  m_axis_result_tready  in   1     downstream ready
//  m_axis_result_tuser   out  1     inexact flag (only with FIX2FLT_INEXACT_EN)
// BEHAVIOUR
//  - Reset: valid and data pipes cleared; m_axis_result_tvalid=0, m_axis_result_tdata=0, s_axis_a_tready=1, tuser=0.
//  - Reset mid-operation: all in-flight beats dropped; no partial output after release.
//  - Handshake: can_advance = m_axis_result_tready || !m_axis_result_tvalid; s_axis_a_tready = can_advance (combinational).
//  - All stages advance together on can_advance; bubbles (valid=0) also shift. Stall holds every stage and m_axis_* stable.
//  - Latency 4 cycles accept->valid with no backpressure; throughput 1 beat/cycle.
//  - S1: sign = msb; mag = |x| as SIZE-bit unsigned (most-negative -> 2^(SIZE-1), no overflow).
//  - S2: lz = leading-zero count of mag; zero flag = (mag==0).
//  - S3: norm = mag << lz (msb at bit SIZE-1); exp = (SIZE-1-lz) - FRAC_BITS + 1023.
//  - S4: mantissa = 52 bits below hidden 1; guard = next bit, sticky = OR of rest (zero if SIZE<=53).
//        Round up iff guard && (sticky || mant lsb). Mantissa carry-out -> mant=0, exp+1.
//  - Zero input -> +0.0 (64'h0); never -0.0. No Inf/NaN/subnormal reachable within parameter limits.
//  - Integer results exact for |x| <= 2^53; above that RNE applies.
// CONFIGURATION
//  - Macro FIX2FLT_INEXACT_EN: when defined, m_axis_result_tuser present, = (guard||sticky) for that beat,
//    pipelined alongside data. When undefined, port and guard/sticky-flag registers absent; tdata identical.
// STRUCTURE
//  - Package fp_pkg: DOUBLE_EXP_W=11, DOUBLE_MANT_W=52, DOUBLE_EXP_BIAS=1023,
//    typedef struct packed {logic sign; logic [10:0] exp; logic [51:0] mant;} double_t.
//  - Sub-module fixed_to_float_lzc #(W): combinational leading-zero counter, out width $clog2(W)+1, W on all-zero.
//  - Top holds per-stage data/valid registers and the shared can_advance stall.
// TESTING
//  1. x=1 (SIZE=64,FRAC_BITS=0) -> 64'h3FF0000000000000 exactly 4 cycles after accept.
//  2. x=-2 -> 64'hC000000000000000; x=0 -> 64'h0; x=-2^63 -> 64'hC3E0000000000000.
//  3. RNE: x=2^53+1 -> 64'h4340000000000000 (tie to even); x=2^53+3 -> 64'h4340000000000002; inexact=1 both if enabled.
//  4. FRAC_BITS=16, SIZE=32: x=32'h00018000 (1.5) -> 64'h3FF8000000000000, inexact=0.
//  5. Stream 8 beats, hold m_axis_result_tready=0 for 5 cycles mid-stream -> s_axis_a_tready=0 while output valid stalled,
//     no loss/duplication, output order matches input, tdata stable during stall.
//  6. Assert aresetn=1 with 3 beats in flight -> tvalid drops asynchronously, none of the 3 appear after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 binary64 field widths and packed layout for the double FP datapath.
package fp_pkg;

  localparam int DOUBLE_EXP_W    = 11;
  localparam int DOUBLE_MANT_W   = 52;
  localparam int DOUBLE_EXP_BIAS = 1023;

  // Normalised operands are left-aligned into this width so guard/sticky
  // extraction is the same slice for every input width up to 64.
  localparam int ALIGN_W = 128;

  typedef struct packed {
    logic                     sign;
    logic [DOUBLE_EXP_W-1:0]  exp;
    logic [DOUBLE_MANT_W-1:0] mant;
  } double_t;

endpackage

// File: rtl/fixed_to_float_if.sv
// AXI-Stream operand/result bundle for fixed_to_float; tuser exists only with FIX2FLT_INEXACT_EN.
interface fixed_to_float_if #(
  parameter int SIZE = 64
);

  logic [SIZE-1:0] s_axis_a_tdata;
  logic            s_axis_a_tvalid;
  logic            s_axis_a_tready;
  logic [63:0]     m_axis_result_tdata;
  logic            m_axis_result_tvalid;
  logic            m_axis_result_tready;

`ifdef FIX2FLT_INEXACT_EN
  logic            m_axis_result_tuser;

  modport master (
    output s_axis_a_tdata, s_axis_a_tvalid, m_axis_result_tready,
    input  s_axis_a_tready, m_axis_result_tdata, m_axis_result_tvalid, m_axis_result_tuser
  );

  modport slave (
    input  s_axis_a_tdata, s_axis_a_tvalid, m_axis_result_tready,
    output s_axis_a_tready, m_axis_result_tdata, m_axis_result_tvalid, m_axis_result_tuser
  );
`else
  modport master (
    output s_axis_a_tdata, s_axis_a_tvalid, m_axis_result_tready,
    input  s_axis_a_tready, m_axis_result_tdata, m_axis_result_tvalid
  );

  modport slave (
    input  s_axis_a_tdata, s_axis_a_tvalid, m_axis_result_tready,
    output s_axis_a_tready, m_axis_result_tdata, m_axis_result_tvalid
  );
`endif

endinterface

// File: rtl/fixed_to_float_lzc.sv
// Combinational leading-zero counter; returns W for an all-zero vector.
module fixed_to_float_lzc #(
  parameter int W = 64
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W):0]   count
);

  localparam int CW = $clog2(W) + 1;

  // Scanning upward lets the highest set bit overwrite lower hits.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fixed_to_float.sv
// Signed fixed-point (SIZE bits, FRAC_BITS fraction) to binary64 with RNE; 4-cycle latency, 1 beat/cycle.
// All stages stall together on output backpressure; FIX2FLT_INEXACT_EN adds the tuser inexact flag.
module fixed_to_float
  import fp_pkg::*;
#(
  parameter int SIZE      = 64,
  parameter int FRAC_BITS = 0
) (
  input  logic            aclk,
  input  logic            aresetn,
  fixed_to_float_if.slave bus
);

  localparam int LZW    = $clog2(SIZE) + 1;
  localparam int FRAC_W = ALIGN_W - 1;
  localparam int PAD    = ALIGN_W - SIZE;
  localparam logic [DOUBLE_EXP_W-1:0] EXP_TOP =
    DOUBLE_EXP_W'(DOUBLE_EXP_BIAS + SIZE - 1 - FRAC_BITS);

  logic can_advance;

  logic            s1_vld;
  logic            s1_sign;
  logic [SIZE-1:0] s1_mag;

  logic            s2_vld;
  logic            s2_sign;
  logic            s2_zero;
  logic [SIZE-1:0] s2_mag;
  logic [LZW-1:0]  s2_lz;
  logic [LZW-1:0]  lz_c;

  logic                    s3_vld;
  logic                    s3_sign;
  logic [SIZE-1:0]         s3_norm;
  logic [DOUBLE_EXP_W-1:0] s3_exp;

  logic        out_vld;
  logic [63:0] out_dat;

  assign can_advance         = bus.m_axis_result_tready || !out_vld;
  assign bus.s_axis_a_tready = can_advance;

  // S1: sign/magnitude. Negating the most-negative value wraps to 2^(SIZE-1),
  // which is exactly its magnitude when read as unsigned.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
    end else if (can_advance) begin
      s1_vld  <= bus.s_axis_a_tvalid;
      s1_sign <= bus.s_axis_a_tdata[SIZE-1];
      s1_mag  <= bus.s_axis_a_tdata[SIZE-1] ? -bus.s_axis_a_tdata : bus.s_axis_a_tdata;
    end
  end

  fixed_to_float_lzc #(.W(SIZE)) u_lzc (
    .vec   (s1_mag),
    .count (lz_c)
  );

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_mag  <= '0;
      s2_lz   <= '0;
    end else if (can_advance) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_zero <= (s1_mag == '0);
      s2_mag  <= s1_mag;
      s2_lz   <= lz_c;
    end
  end

  // S3: normalise so the leading one sits at bit SIZE-1.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      s3_vld  <= 1'b0;
      s3_sign <= 1'b0;
      s3_norm <= '0;
      s3_exp  <= '0;
    end else if (can_advance) begin
      s3_vld  <= s2_vld;
      s3_sign <= s2_sign;
      s3_norm <= s2_mag << s2_lz;
      s3_exp  <= s2_zero ? '0 : EXP_TOP - {{(DOUBLE_EXP_W-LZW){1'b0}}, s2_lz};
    end
  end

  logic [FRAC_W-1:0]        aligned;
  logic [DOUBLE_MANT_W-1:0] mant;
  logic                     guard;
  logic                     sticky;
  logic                     round_up;
  logic [DOUBLE_MANT_W:0]   mant_sum;
  logic [DOUBLE_EXP_W-1:0]  exp_r;
  double_t                  result;

  // S4: round to nearest even. A mantissa carry-out leaves the field all zero,
  // which is the correct mantissa for the bumped exponent.
  always_comb begin
    aligned  = {s3_norm[SIZE-2:0], {PAD{1'b0}}};
    mant     = aligned[FRAC_W-1 -: DOUBLE_MANT_W];
    guard    = aligned[FRAC_W-1-DOUBLE_MANT_W];
    sticky   = |aligned[FRAC_W-2-DOUBLE_MANT_W:0];
    round_up = guard && (sticky || mant[0]);
    mant_sum = {1'b0, mant} + {{DOUBLE_MANT_W{1'b0}}, round_up};
    exp_r    = s3_exp + {{(DOUBLE_EXP_W-1){1'b0}}, mant_sum[DOUBLE_MANT_W]};
    result   = '0;
    // The hidden bit is clear only for a zero operand, which must come out as +0.0.
    if (s3_norm[SIZE-1]) begin
      result.sign = s3_sign;
      result.exp  = exp_r;
      result.mant = mant_sum[DOUBLE_MANT_W-1:0];
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (can_advance) begin
      out_vld <= s3_vld;
      out_dat <= result;
    end
  end

  assign bus.m_axis_result_tvalid = out_vld;
  assign bus.m_axis_result_tdata  = out_dat;

`ifdef FIX2FLT_INEXACT_EN
  logic out_inexact;

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      out_inexact <= 1'b0;
    end else if (can_advance) begin
      out_inexact <= guard || sticky;
    end
  end

  assign bus.m_axis_result_tuser = out_inexact;
`endif

endmodule

// File: tb/tb_fixed_to_float.sv
// Bench for fixed_to_float: 64-bit integer and 32-bit Q16 instances with queue scoreboards.
module tb_fixed_to_float;

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  fixed_to_float_if #(.SIZE(64)) bus64 ();
  fixed_to_float_if #(.SIZE(32)) bus32 ();

  fixed_to_float #(.SIZE(64), .FRAC_BITS(0)) dut64 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus64)
  );

  fixed_to_float #(.SIZE(32), .FRAC_BITS(16)) dut32 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus32)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        inx;
  } exp_t;

  typedef struct {
    logic [63:0] x;
    logic [63:0] res;
    logic        inx;
  } vec_t;

  exp_t q64[$];
  exp_t q32[$];
  vec_t tab64[14];
  vec_t tab32[4];
  int   checks = 0;
  int   errors = 0;
  int   outs64 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Output monitors: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge aclk) begin : mon64
    exp_t e;
    if (!aresetn && bus64.m_axis_result_tvalid && bus64.m_axis_result_tready) begin
      outs64++;
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out64_unexpected: got %h required no beat", bus64.m_axis_result_tdata);
      end else begin
        e = q64.pop_front();
        chk("out64", bus64.m_axis_result_tdata, e.res);
`ifdef FIX2FLT_INEXACT_EN
        chk("inexact64", {63'b0, bus64.m_axis_result_tuser}, {63'b0, e.inx});
`endif
      end
    end
  end

  always @(negedge aclk) begin : mon32
    exp_t e;
    if (!aresetn && bus32.m_axis_result_tvalid && bus32.m_axis_result_tready) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out32_unexpected: got %h required no beat", bus32.m_axis_result_tdata);
      end else begin
        e = q32.pop_front();
        chk("out32", bus32.m_axis_result_tdata, e.res);
`ifdef FIX2FLT_INEXACT_EN
        chk("inexact32", {63'b0, bus32.m_axis_result_tuser}, {63'b0, e.inx});
`endif
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with tvalid still high.
  task automatic send64(input logic [63:0] x, input logic [63:0] res, input logic inx);
    logic ok;
    ok = 1'b0;
    bus64.s_axis_a_tdata  = x;
    bus64.s_axis_a_tvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge aclk);
      if (bus64.s_axis_a_tready) ok = 1'b1;
      else begin
        @(posedge aclk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send64_timeout: got tready=0 required tready=1 within 100 cycles");
    end else begin
      q64.push_back('{res: res, inx: inx});
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send32(input logic [31:0] x, input logic [63:0] res, input logic inx);
    logic ok;
    ok = 1'b0;
    bus32.s_axis_a_tdata  = x;
    bus32.s_axis_a_tvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge aclk);
      if (bus32.s_axis_a_tready) ok = 1'b1;
      else begin
        @(posedge aclk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send32_timeout: got tready=0 required tready=1 within 100 cycles");
    end else begin
      q32.push_back('{res: res, inx: inx});
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (q64.size() != 0 || q32.size() != 0); n++) @(posedge aclk);
    #1;
    chk("drain64_pending", 64'(q64.size()), 64'd0);
    chk("drain32_pending", 64'(q32.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000 time units");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int          lat;
    int          outs_before;
    logic [63:0] hold;

    tab64[0]  = '{64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b0};
    tab64[1]  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hC000_0000_0000_0000, 1'b0};
    tab64[2]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
    tab64[3]  = '{64'h8000_0000_0000_0000, 64'hC3E0_0000_0000_0000, 1'b0};
    tab64[4]  = '{64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, 1'b1};
    tab64[5]  = '{64'h0020_0000_0000_0003, 64'h4340_0000_0000_0002, 1'b1};
    tab64[6]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h43E0_0000_0000_0000, 1'b1};
    tab64[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000, 1'b0};
    tab64[8]  = '{64'h0000_0000_0000_0003, 64'h4008_0000_0000_0000, 1'b0};
    tab64[9]  = '{64'h0020_0000_0000_0000, 64'h4340_0000_0000_0000, 1'b0};
    tab64[10] = '{64'h0020_0000_0000_0002, 64'h4340_0000_0000_0001, 1'b0};
    tab64[11] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'hC014_0000_0000_0000, 1'b0};
    tab64[12] = '{64'h0040_0000_0000_0002, 64'h4350_0000_0000_0000, 1'b1};
    tab64[13] = '{64'h0040_0000_0000_0006, 64'h4350_0000_0000_0002, 1'b1};

    tab32[0]  = '{64'h0000_0000_0001_8000, 64'h3FF8_0000_0000_0000, 1'b0};
    tab32[1]  = '{64'h0000_0000_FFFF_8000, 64'hBFE0_0000_0000_0000, 1'b0};
    tab32[2]  = '{64'h0000_0000_8000_0000, 64'hC0E0_0000_0000_0000, 1'b0};
    tab32[3]  = '{64'h0000_0000_0000_0001, 64'h3EF0_0000_0000_0000, 1'b0};

    aresetn                    = 1'b1;
    bus64.s_axis_a_tdata       = '0;
    bus64.s_axis_a_tvalid      = 1'b0;
    bus64.m_axis_result_tready = 1'b1;
    bus32.s_axis_a_tdata       = '0;
    bus32.s_axis_a_tvalid      = 1'b0;
    bus32.m_axis_result_tready = 1'b1;

    #12;
    chk("rst_tvalid64", {63'b0, bus64.m_axis_result_tvalid}, 64'd0);
    chk("rst_tdata64",  bus64.m_axis_result_tdata, 64'd0);
    chk("rst_tready64", {63'b0, bus64.s_axis_a_tready}, 64'd1);
    chk("rst_tvalid32", {63'b0, bus32.m_axis_result_tvalid}, 64'd0);
    chk("rst_tdata32",  bus32.m_axis_result_tdata, 64'd0);
`ifdef FIX2FLT_INEXACT_EN
    chk("rst_tuser64",  {63'b0, bus64.m_axis_result_tuser}, 64'd0);
`endif
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Latency: count the accepting edge as 1.
    send64(64'd1, 64'h3FF0_0000_0000_0000, 1'b0);
    bus64.s_axis_a_tvalid = 1'b0;
    lat = 1;
    while (!bus64.m_axis_result_tvalid && lat < 20) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    drain();

    for (int i = 0; i < 14; i++) send64(tab64[i].x, tab64[i].res, tab64[i].inx);
    bus64.s_axis_a_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) send32(tab32[i].x[31:0], tab32[i].res, tab32[i].inx);
    bus32.s_axis_a_tvalid = 1'b0;
    drain();

    // Eight-beat stream with a five-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send64(tab64[i].x, tab64[i].res, tab64[i].inx);
        bus64.s_axis_a_tvalid = 1'b0;
      end
      begin
        repeat (5) @(posedge aclk);
        #1;
        bus64.m_axis_result_tready = 1'b0;
        hold = bus64.m_axis_result_tdata;
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          chk("stall_s_tready", {63'b0, bus64.s_axis_a_tready}, 64'd0);
          chk("stall_tvalid",   {63'b0, bus64.m_axis_result_tvalid}, 64'd1);
          chk("stall_tdata",    bus64.m_axis_result_tdata, hold);
        end
        @(posedge aclk);
        #1;
        bus64.m_axis_result_tready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight, output stalled so none escape first.
    bus64.m_axis_result_tready = 1'b0;
    for (int i = 8; i < 11; i++) send64(tab64[i].x, tab64[i].res, tab64[i].inx);
    bus64.s_axis_a_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    chk("pre_rst_tvalid", {63'b0, bus64.m_axis_result_tvalid}, 64'd1);
    outs_before = outs64;
    #2;
    aresetn = 1'b1;
    q64.delete();
    #1;
    chk("async_rst_tvalid", {63'b0, bus64.m_axis_result_tvalid}, 64'd0);
    chk("async_rst_tdata",  bus64.m_axis_result_tdata, 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    bus64.m_axis_result_tready = 1'b1;
    repeat (10) @(posedge aclk);
    #1;
    chk("no_beats_after_rst", 64'(outs64 - outs_before), 64'd0);

    send64(tab64[11].x, tab64[11].res, tab64[11].inx);
    bus64.s_axis_a_tvalid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
